// File: rtl/lfsr_share_ctrl.sv
// Shared Galois LFSR word source: round-robin arbitration hands one fresh
// pseudo-random word per grant, with seed loading, zero-seed recovery and
// period tracking.
module lfsr_share_ctrl #(
    parameter int unsigned     DATA = 8,
    parameter logic [DATA-1:0] TAPS = 'hB8,
    parameter int unsigned     REQ  = 4,
    parameter logic [DATA-1:0] SEED = 'd1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            seed_load,
    input  logic [DATA-1:0] seed_data,
    input  logic [REQ-1:0]  req,
    output logic [REQ-1:0]  gnt,
    output logic [DATA-1:0] rdata,
    output logic            ready,
    output logic            period_done,
    output logic            lock_err
);

    localparam int unsigned PW = (REQ > 1) ? $clog2(REQ) : 1;
    // Last counter value before the wrap: 2^DATA - 2.
    localparam logic [DATA-1:0] CNT_LAST = {{(DATA-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {StInit, StServe, StSeed} state_e;

    state_e          state_q;
    logic [DATA-1:0] s_q;
    logic [DATA-1:0] cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [REQ-1:0]  gnt_q;
    logic [DATA-1:0] rdata_q;
    logic            ready_q;
    logic            period_done_q;
    logic            lock_err_q;

    logic            arb_vld;
    logic [PW-1:0]   arb_idx;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   ptr_next;
    logic [DATA-1:0] s_next;
    logic [REQ-1:0]  arb_onehot;

    // Round-robin search starting at the pointer; first set request wins.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < REQ; i++) begin
            cand = PW'((32'(ptr_q) + i) % REQ);
            if (!arb_vld && req[cand]) begin
                arb_vld = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Pointer successor, LFSR advance and grant vector for the winner.
    always_comb begin
        ptr_next   = (arb_idx == PW'(REQ - 1)) ? '0 : arb_idx + PW'(1);
        s_next     = (s_q >> 1) ^ (s_q[0] ? TAPS : '0);
        arb_onehot = REQ'(1) << arb_idx;
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StInit;
            s_q           <= SEED;
            cnt_q         <= '0;
            ptr_q         <= '0;
            gnt_q         <= '0;
            rdata_q       <= '0;
            ready_q       <= 1'b0;
            period_done_q <= 1'b0;
            lock_err_q    <= 1'b0;
        end else begin
            gnt_q         <= '0;
            period_done_q <= 1'b0;
            unique case (state_q)
                StInit: begin
                    state_q <= StServe;
                    ready_q <= 1'b1;
                end
                StServe: begin
                    if (seed_load) begin
                        // Seed load pre-empts arbitration; pointer is left alone.
                        state_q <= StSeed;
                        ready_q <= 1'b0;
                        cnt_q   <= '0;
                        if (seed_data == '0) begin
                            s_q        <= SEED;
                            lock_err_q <= 1'b1;
                        end else begin
                            s_q <= seed_data;
                        end
                    end else if (arb_vld) begin
                        gnt_q   <= arb_onehot;
                        rdata_q <= s_q;
                        s_q     <= s_next;
                        ptr_q   <= ptr_next;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q         <= '0;
                            period_done_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + DATA'(1);
                        end
                    end
                end
                StSeed: begin
                    state_q <= StServe;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StInit;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign rdata       = rdata_q;
    assign ready       = ready_q;
    assign period_done = period_done_q;
    assign lock_err    = lock_err_q;

endmodule

// File: doc/lfsr_share_ctrl.md
# lfsr_share_ctrl

Shared pseudo-random source controller. Owns one Galois LFSR state register and hands out one fresh word per grant to up to REQ requesters, using round-robin arbitration with a registered req/gnt handshake. Also handles seed configuration, all-zero lock-up recovery and period tracking. It sits between consumers of random words (scramblers, random-replacement logic, traffic generators) and the LFSR datapath it sequences.

## Interface
- DATA, 8: LFSR width in bits; 3 to 32.
- TAPS, 8'hB8: Galois feedback mask, DATA bits wide; must describe a maximal-length polynomial.
- REQ, 4: number of requesters; 2 to 16.
- SEED, 1: reset and recovery seed; must be non-zero.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- seed_load  in  1  load seed_data into the LFSR this cycle.
- seed_data  in  DATA  new seed value.
- req  in  REQ  per-requester request; level, held until granted.
- gnt  out  REQ  registered one-hot grant pulse, one cycle.
- rdata  out  DATA  random word; valid in the same cycle as gnt.
- ready  out  1  high when the block is in SERVE and can issue grants.
- period_done  out  1  one-cycle pulse when 2^DATA-1 advances complete since the last seed.
- lock_err  out  1  sticky flag; set when a zero seed was rejected.

## Operation
- LFSR advance: next = (s >> 1) ^ (s[0] ? TAPS : 0). The state advances only on a grant.
- FSM states: INIT, SERVE, SEED.
  - Reset: the FSM enters INIT, s = SEED, and the round-robin pointer is 0.
  - INIT -> SERVE after one cycle.
  - SERVE -> SEED when seed_load = 1.
  - SEED -> SERVE after one cycle.
- SEED cycle: no grant is issued and s holds the loaded value.
- Seed load in SERVE:
  - A non-zero seed_data is written to s.
  - seed_data = 0 writes SEED instead and sets lock_err.
  - The period counter clears in both cases.
- seed_load in INIT or SEED is ignored.
- Arbitration:
  - Only in SERVE, with no seed_load in the same cycle.
  - Search req starting at the pointer and grant the first set bit.
  - The pointer then moves to granted index + 1, mod REQ.
  - At most one grant per cycle.
- On a grant:
  - rdata is registered as the current s (pre-advance), and gnt is set for that index.
  - s advances, and the period counter increments.
- Period counter: DATA bits wide.
  - When it reaches 2^DATA-2 and a grant occurs, it wraps to 0 and period_done pulses with that gnt.
- lock_err clears only on reset.
- rdata holds its last value when no grant is issued.

## Timing
- Reset values: gnt = 0, rdata = 0, ready = 0, period_done = 0, lock_err = 0. Reset acts immediately and asynchronously.
- ready is 1 in SERVE and 0 in INIT and SEED. It is registered from the FSM state.
- Grant latency:
  - req sampled at edge k gives gnt and rdata during cycle k..k+1.
  - The first possible grant is at the second edge after reset is released.
- Handshake:
  - A requester drops req in the cycle after it sees gnt.
  - If req is still high it is re-arbitrated, but at the lowest priority because the pointer has moved past it.
- Back-to-back grants are allowed, one per cycle, so throughput is 1 word per cycle.
- seed_load and req asserted together: seed_load wins, with no grant and the pointer unchanged. The request is served from the cycle after SEED.
- If reset is asserted mid-grant, the gnt pulse is cut immediately and the sequence restarts from SEED.
- Uniqueness: every word is granted to exactly one requester, and 2^DATA-1 consecutive grants cover every non-zero value once.

## Test plan
- Reset, then hold req = 4'b0001 continuously:
  - The first gnt appears at the second edge after reset release.
  - rdata sequence is 0x01, 0xB8, 0x5C, 0x2E, 0x17, 0xB3.
- req = 4'b1111 held continuously: gnt rotates 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and rdata follows the same sequence as above.
- 255 consecutive grants from seed 0x01:
  - All non-zero values occur once and 0x00 never occurs.
  - period_done pulses exactly with the 255th grant.
- seed_load = 1 with seed_data = 0x5C while req = 4'b0010:
  - No gnt and ready = 0 for one cycle.
  - The next gnt is 0010 with rdata = 0x5C, then the following grant returns 0x2E.
- seed_load with seed_data = 0x00: lock_err = 1 and stays set, and the next granted rdata = 0x01.
- Assert reset in the middle of a 4-requester stream:
  - gnt, rdata, ready and lock_err go to 0 at once.
  - After release the sequence restarts at 0x01 with requester 0 first.
